mos6502_alu_stage: RTL and testbench

//  Multi-cycle 6502 ALU: the stage directly upstream of accumulator register A.

---
 rtl/mos6502_alu_stage.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_mos6502_alu_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mos6502_alu_stage.sv
// ---------------------------------------------------------------------------
// mos6502_alu_stage
//
// Multi-cycle 6502 ALU sitting directly upstream of accumulator register A.
// An operation is accepted from the control FSM in IDLE. Its operands are
// latched, the result is computed (with an optional BCD adjust cycle), and
// OUT_ALU is presented together with a one-cycle load_A strobe for register A.
// N/V/Z/C results and an update mask are returned for the status register.
//
// Parameters
//   DECIMAL_EN   1 = honour decimal_in for ADC/SBC, 0 = binary only
//
// Ports
//   FSM_Signal   in   1  clock, rising edge
//   reset_ALU    in   1  synchronous active-high reset
//   start        in   1  operation request, sampled only in IDLE
//   op           in   4  0 ADC,1 SBC,2 AND,3 ORA,4 EOR,5 ASL,6 LSR,7 ROL,
//                        8 ROR,9 INC,A DEC,B CMP,C PASSB, D-F reserved
//   IN_ALU_A     in   8  operand A (accumulator or memory byte)
//   IN_ALU_B     in   8  operand B
//   carry_in     in   1  C flag in
//   decimal_in   in   1  D flag in
//   OUT_ALU      out  8  registered result, held until next result or reset
//   load_A       out  1  one-cycle write strobe toward register A
//   done         out  1  one-cycle completion pulse
//   busy         out  1  high whenever the FSM is not in IDLE
//   flag_N/V/Z/C out  1  flag results, registered with OUT_ALU
//   flag_mask    out  4  {N,V,Z,C} flags updated by this op
//   o_dbg_state  out  2  current FSM state (0 IDLE,1 EXEC,2 DEC_ADJ,3 DONE)
//
// Handshake: start is a request that is only looked at while busy is low;
// a request raised while busy is high is dropped, never queued. Each accepted
// request produces exactly one done pulse (unless reset intervenes), and
// load_A, when issued, coincides with that done pulse.
// ---------------------------------------------------------------------------
module mos6502_alu_stage #(
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic       FSM_Signal,
    input  logic       reset_ALU,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [7:0] IN_ALU_A,
    input  logic [7:0] IN_ALU_B,
    input  logic       carry_in,
    input  logic       decimal_in,
    output logic [7:0] OUT_ALU,
    output logic       load_A,
    output logic       done,
    output logic       busy,
    output logic       flag_N,
    output logic       flag_V,
    output logic       flag_Z,
    output logic       flag_C,
    output logic [3:0] flag_mask,
    output logic [1:0] o_dbg_state
);

    localparam logic [3:0] OP_ADC   = 4'h0;
    localparam logic [3:0] OP_SBC   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_ORA   = 4'h3;
    localparam logic [3:0] OP_EOR   = 4'h4;
    localparam logic [3:0] OP_ASL   = 4'h5;
    localparam logic [3:0] OP_LSR   = 4'h6;
    localparam logic [3:0] OP_ROL   = 4'h7;
    localparam logic [3:0] OP_ROR   = 4'h8;
    localparam logic [3:0] OP_INC   = 4'h9;
    localparam logic [3:0] OP_DEC   = 4'hA;
    localparam logic [3:0] OP_CMP   = 4'hB;
    localparam logic [3:0] OP_PASSB = 4'hC;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_DEC_ADJ = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    // Operands captured on acceptance; later input changes are ignored.
    logic [3:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_cin;
    logic       r_dec;

    // Binary datapath
    logic [7:0] w_b_eff;
    logic       w_cin_eff;
    logic [8:0] w_sum9;
    logic [7:0] w_res;
    logic       w_n, w_v, w_z, w_c;
    logic [3:0] w_mask;

    // BCD adjust datapath
    logic [4:0] w_lo5;
    logic [4:0] w_hi5;
    logic       w_lo_carry;
    logic [3:0] w_lo_nib;
    logic [3:0] w_hi_nib;
    logic       w_dec_c;
    logic [7:0] w_dec_res;

    logic       w_use_dec;
    logic       w_load_ok;

    assign w_use_dec = DECIMAL_EN && r_dec && ((r_op == OP_ADC) || (r_op == OP_SBC));
    // CMP and reserved codes never write the accumulator.
    assign w_load_ok = (r_op != OP_CMP) && (r_op <= OP_PASSB);

    // ---------------- binary result ----------------
    always_comb begin
        w_b_eff   = r_b;
        w_cin_eff = r_cin;
        if ((r_op == OP_SBC) || (r_op == OP_CMP)) begin
            w_b_eff = ~r_b;
        end
        // CMP is a subtraction with no incoming borrow.
        if (r_op == OP_CMP) begin
            w_cin_eff = 1'b1;
        end
        w_sum9 = {1'b0, r_a} + {1'b0, w_b_eff} + {8'd0, w_cin_eff};
    end

    always_comb begin
        w_res  = 8'h00;
        w_v    = 1'b0;
        w_c    = 1'b0;
        w_mask = 4'b0000;
        case (r_op)
            OP_ADC: begin
                w_res  = w_sum9[7:0];
                w_c    = w_sum9[8];
                w_v    = (r_a[7] == r_b[7]) && (w_sum9[7] != r_a[7]);
                w_mask = 4'b1111;
            end
            OP_SBC: begin
                w_res  = w_sum9[7:0];
                w_c    = w_sum9[8];
                w_v    = (r_a[7] != r_b[7]) && (w_sum9[7] != r_a[7]);
                w_mask = 4'b1111;
            end
            OP_AND: begin
                w_res  = r_a & r_b;
                w_mask = 4'b1010;
            end
            OP_ORA: begin
                w_res  = r_a | r_b;
                w_mask = 4'b1010;
            end
            OP_EOR: begin
                w_res  = r_a ^ r_b;
                w_mask = 4'b1010;
            end
            OP_ASL: begin
                w_res  = {r_a[6:0], 1'b0};
                w_c    = r_a[7];
                w_mask = 4'b1011;
            end
            OP_LSR: begin
                w_res  = {1'b0, r_a[7:1]};
                w_c    = r_a[0];
                w_mask = 4'b1011;
            end
            OP_ROL: begin
                w_res  = {r_a[6:0], r_cin};
                w_c    = r_a[7];
                w_mask = 4'b1011;
            end
            OP_ROR: begin
                w_res  = {r_cin, r_a[7:1]};
                w_c    = r_a[0];
                w_mask = 4'b1011;
            end
            OP_INC: begin
                w_res  = r_a + 8'd1;
                w_mask = 4'b1010;
            end
            OP_DEC: begin
                w_res  = r_a - 8'd1;
                w_mask = 4'b1010;
            end
            OP_CMP: begin
                w_res  = w_sum9[7:0];
                w_c    = w_sum9[8];
                w_mask = 4'b1011;
            end
            OP_PASSB: begin
                w_res  = r_b;
                w_mask = 4'b1010;
            end
            default: begin
                w_res  = 8'h00;
                w_mask = 4'b0000;
            end
        endcase
        // Flags outside the mask are forced to 0.
        w_n = w_mask[3] & w_res[7];
        w_z = w_mask[1] & (w_res == 8'h00);
    end

    // ---------------- BCD adjust ----------------
    // Nibble-wise sum from the latched operands. For SBC the low-nibble carry
    // out is "no borrow"; the same 5-bit adders serve both directions.
    always_comb begin
        w_lo5      = {1'b0, r_a[3:0]} + {1'b0, w_b_eff[3:0]} + {4'd0, r_cin};
        w_lo_carry = 1'b0;
        w_lo_nib   = w_lo5[3:0];
        w_hi5      = 5'd0;
        w_hi_nib   = 4'd0;
        w_dec_c    = 1'b0;
        if (r_op == OP_ADC) begin
            w_lo_carry = (w_lo5 > 5'd9);
            if (w_lo_carry) begin
                w_lo_nib = w_lo5[3:0] + 4'd6;
            end
            w_hi5    = {1'b0, r_a[7:4]} + {1'b0, r_b[7:4]} + {4'd0, w_lo_carry};
            w_dec_c  = (w_hi5 > 5'd9);
            w_hi_nib = w_dec_c ? (w_hi5[3:0] + 4'd6) : w_hi5[3:0];
        end else begin
            w_lo_carry = w_lo5[4];
            if (!w_lo_carry) begin
                w_lo_nib = w_lo5[3:0] - 4'd6;
            end
            w_hi5    = {1'b0, r_a[7:4]} + {1'b0, w_b_eff[7:4]} + {4'd0, w_lo_carry};
            w_hi_nib = w_hi5[4] ? w_hi5[3:0] : (w_hi5[3:0] - 4'd6);
            // Decimal SBC reports the binary carry.
            w_dec_c  = w_sum9[8];
        end
        w_dec_res = {w_hi_nib, w_lo_nib};
    end

    // ---------------- FSM ----------------
    always_comb begin
        w_next_state = r_state;
        done         = 1'b0;
        load_A       = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = w_use_dec ? S_DEC_ADJ : S_DONE;
            end
            S_DEC_ADJ: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                load_A       = w_load_ok;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign o_dbg_state = r_state;

    always_ff @(posedge FSM_Signal) begin
        if (reset_ALU) begin
            r_state   <= S_IDLE;
            r_op      <= 4'h0;
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_cin     <= 1'b0;
            r_dec     <= 1'b0;
            OUT_ALU   <= 8'h00;
            flag_N    <= 1'b0;
            flag_V    <= 1'b0;
            flag_Z    <= 1'b0;
            flag_C    <= 1'b0;
            flag_mask <= 4'b0000;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && start) begin
                r_op  <= op;
                r_a   <= IN_ALU_A;
                r_b   <= IN_ALU_B;
                r_cin <= carry_in;
                r_dec <= decimal_in;
            end
            if ((r_state == S_EXEC) && !w_use_dec) begin
                OUT_ALU   <= w_res;
                flag_N    <= w_n;
                flag_V    <= w_v;
                flag_Z    <= w_z;
                flag_C    <= w_c;
                flag_mask <= w_mask;
            end else if (r_state == S_DEC_ADJ) begin
                // V keeps the binary result; N/Z follow the adjusted byte.
                OUT_ALU   <= w_dec_res;
                flag_N    <= w_dec_res[7];
                flag_V    <= w_v;
                flag_Z    <= (w_dec_res == 8'h00);
                flag_C    <= w_dec_c;
                flag_mask <= 4'b1111;
            end
        end
    end

endmodule

// File: tb/tb_mos6502_alu_stage.sv
module tb_mos6502_alu_stage;

    logic       clk = 1'b0;
    logic       reset_ALU;
    logic       start;
    logic [3:0] op;
    logic [7:0] IN_ALU_A;
    logic [7:0] IN_ALU_B;
    logic       carry_in;
    logic       decimal_in;
    logic [7:0] OUT_ALU;
    logic       load_A;
    logic       done;
    logic       busy;
    logic       flag_N, flag_V, flag_Z, flag_C;
    logic [3:0] flag_mask;
    logic [1:0] o_dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       dec;
        int         lat;
        logic [7:0] out;
        logic [3:0] fl;
        logic [3:0] mk;
        logic       ld;
    } vec_t;

    mos6502_alu_stage #(.DECIMAL_EN(1'b1)) dut (
        .FSM_Signal (clk),
        .reset_ALU  (reset_ALU),
        .start      (start),
        .op         (op),
        .IN_ALU_A   (IN_ALU_A),
        .IN_ALU_B   (IN_ALU_B),
        .carry_in   (carry_in),
        .decimal_in (decimal_in),
        .OUT_ALU    (OUT_ALU),
        .load_A     (load_A),
        .done       (done),
        .busy       (busy),
        .flag_N     (flag_N),
        .flag_V     (flag_V),
        .flag_Z     (flag_Z),
        .flag_C     (flag_C),
        .flag_mask  (flag_mask),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    function automatic vec_t mk(input string n, input logic [3:0] o, input logic [7:0] a,
                                input logic [7:0] b, input logic c, input logic d,
                                input int lat, input logic [7:0] out, input logic [3:0] fl,
                                input logic [3:0] m, input logic ld);
        vec_t v;
        v.name = n; v.op = o; v.a = a; v.b = b; v.cin = c; v.dec = d;
        v.lat = lat; v.out = out; v.fl = fl; v.mk = m; v.ld = ld;
        return v;
    endfunction

    // Issues one op, scrambles inputs after the accept edge, counts edges
    // (accept edge = 1) until done, and captures outputs in the done cycle.
    task automatic run_op(input vec_t v, output int lat, output logic [7:0] out,
                          output logic [3:0] fl, output logic [3:0] mk_o, output logic ld);
        @(negedge clk);
        op = v.op; IN_ALU_A = v.a; IN_ALU_B = v.b; carry_in = v.cin; decimal_in = v.dec;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = v.op ^ 4'h3; IN_ALU_A = ~v.a; IN_ALU_B = ~v.b;
        carry_in = ~v.cin; decimal_in = ~v.dec;
        lat = 1;
        while ((done !== 1'b1) && (lat < 8)) begin
            @(posedge clk); #1;
            lat++;
        end
        out  = OUT_ALU;
        fl   = {flag_N, flag_V, flag_Z, flag_C};
        mk_o = flag_mask;
        ld   = load_A;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_ALU = 1'b1; start = 1'b1; op = 4'h0;
        IN_ALU_A = 8'h55; IN_ALU_B = 8'hAA; carry_in = 1'b1; decimal_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({OUT_ALU, flag_N, flag_V, flag_Z, flag_C, flag_mask, load_A, done, busy} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h nvzc=%b%b%b%b mask=%b ld=%b done=%b busy=%b want all 0",
                     OUT_ALU, flag_N, flag_V, flag_Z, flag_C, flag_mask, load_A, done, busy);
        end
        checks++;
        if (o_dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", o_dbg_state);
        end
        @(negedge clk);
        reset_ALU = 1'b0; start = 1'b0;
    endtask

    task automatic test_arith();
        vec_t q[$];
        int lat; logic [7:0] out; logic [3:0] fl, m; logic ld;
        q.push_back(mk("adc_bin_50_50", 4'h0, 8'h50, 8'h50, 1'b0, 1'b0, 2, 8'hA0, 4'b1100, 4'b1111, 1'b1));
        q.push_back(mk("adc_dec_58_46", 4'h0, 8'h58, 8'h46, 1'b1, 1'b1, 3, 8'h05, 4'b0101, 4'b1111, 1'b1));
        q.push_back(mk("sbc_bin_00_01", 4'h1, 8'h00, 8'h01, 1'b1, 1'b0, 2, 8'hFF, 4'b1000, 4'b1111, 1'b1));
        q.push_back(mk("sbc_dec_50_25", 4'h1, 8'h50, 8'h25, 1'b1, 1'b1, 3, 8'h25, 4'b0001, 4'b1111, 1'b1));
        q.push_back(mk("adc_bin_ff_01", 4'h0, 8'hFF, 8'h01, 1'b0, 1'b0, 2, 8'h00, 4'b0011, 4'b1111, 1'b1));
        q.push_back(mk("sbc_bin_80_01", 4'h1, 8'h80, 8'h01, 1'b1, 1'b0, 2, 8'h7F, 4'b0101, 4'b1111, 1'b1));
        foreach (q[i]) begin
            run_op(q[i], lat, out, fl, m, ld);
            checks++;
            if (lat !== q[i].lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", q[i].name, lat, q[i].lat); end
            checks++;
            if (out !== q[i].out) begin errors++; $display("FAIL %s out: got %h want %h", q[i].name, out, q[i].out); end
            checks++;
            if (fl !== q[i].fl) begin errors++; $display("FAIL %s nvzc: got %b want %b", q[i].name, fl, q[i].fl); end
            checks++;
            if (m !== q[i].mk) begin errors++; $display("FAIL %s mask: got %b want %b", q[i].name, m, q[i].mk); end
            checks++;
            if (ld !== q[i].ld) begin errors++; $display("FAIL %s load_A: got %b want %b", q[i].name, ld, q[i].ld); end
        end
    endtask

    task automatic test_logic_shift();
        vec_t q[$];
        int lat; logic [7:0] out; logic [3:0] fl, m; logic ld;
        q.push_back(mk("and_f0_3c",   4'h2, 8'hF0, 8'h3C, 1'b0, 1'b0, 2, 8'h30, 4'b0000, 4'b1010, 1'b1));
        q.push_back(mk("ora_80_01",   4'h3, 8'h80, 8'h01, 1'b0, 1'b0, 2, 8'h81, 4'b1000, 4'b1010, 1'b1));
        q.push_back(mk("eor_ff_ff",   4'h4, 8'hFF, 8'hFF, 1'b0, 1'b0, 2, 8'h00, 4'b0010, 4'b1010, 1'b1));
        q.push_back(mk("passb_00_d1", 4'hC, 8'h77, 8'h00, 1'b1, 1'b1, 2, 8'h00, 4'b0010, 4'b1010, 1'b1));
        q.push_back(mk("asl_81",      4'h5, 8'h81, 8'h00, 1'b0, 1'b0, 2, 8'h02, 4'b0001, 4'b1011, 1'b1));
        q.push_back(mk("lsr_01",      4'h6, 8'h01, 8'h00, 1'b1, 1'b0, 2, 8'h00, 4'b0011, 4'b1011, 1'b1));
        q.push_back(mk("rol_80_c0",   4'h7, 8'h80, 8'h00, 1'b0, 1'b0, 2, 8'h00, 4'b0011, 4'b1011, 1'b1));
        q.push_back(mk("rol_40_c1",   4'h7, 8'h40, 8'h00, 1'b1, 1'b0, 2, 8'h81, 4'b1000, 4'b1011, 1'b1));
        q.push_back(mk("ror_01_c1",   4'h8, 8'h01, 8'h00, 1'b1, 1'b0, 2, 8'h80, 4'b1001, 4'b1011, 1'b1));
        q.push_back(mk("inc_ff",      4'h9, 8'hFF, 8'h00, 1'b0, 1'b0, 2, 8'h00, 4'b0010, 4'b1010, 1'b1));
        q.push_back(mk("dec_00",      4'hA, 8'h00, 8'h00, 1'b0, 1'b0, 2, 8'hFF, 4'b1000, 4'b1010, 1'b1));
        foreach (q[i]) begin
            run_op(q[i], lat, out, fl, m, ld);
            checks++;
            if (lat !== q[i].lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", q[i].name, lat, q[i].lat); end
            checks++;
            if (out !== q[i].out) begin errors++; $display("FAIL %s out: got %h want %h", q[i].name, out, q[i].out); end
            checks++;
            if (fl !== q[i].fl) begin errors++; $display("FAIL %s nvzc: got %b want %b", q[i].name, fl, q[i].fl); end
            checks++;
            if (m !== q[i].mk) begin errors++; $display("FAIL %s mask: got %b want %b", q[i].name, m, q[i].mk); end
            checks++;
            if (ld !== q[i].ld) begin errors++; $display("FAIL %s load_A: got %b want %b", q[i].name, ld, q[i].ld); end
        end
    endtask

    task automatic test_cmp_reserved();
        vec_t q[$];
        int lat; logic [7:0] out; logic [3:0] fl, m; logic ld;
        q.push_back(mk("cmp_40_40", 4'hB, 8'h40, 8'h40, 1'b0, 1'b0, 2, 8'h00, 4'b0011, 4'b1011, 1'b0));
        q.push_back(mk("cmp_10_20", 4'hB, 8'h10, 8'h20, 1'b0, 1'b0, 2, 8'hF0, 4'b1000, 4'b1011, 1'b0));
        q.push_back(mk("cmp_20_10", 4'hB, 8'h20, 8'h10, 1'b0, 1'b1, 2, 8'h10, 4'b0001, 4'b1011, 1'b0));
        q.push_back(mk("rsv_d",     4'hD, 8'hFF, 8'hFF, 1'b1, 1'b1, 2, 8'h00, 4'b0000, 4'b0000, 1'b0));
        q.push_back(mk("rsv_e",     4'hE, 8'h80, 8'h01, 1'b1, 1'b0, 2, 8'h00, 4'b0000, 4'b0000, 1'b0));
        q.push_back(mk("rsv_f",     4'hF, 8'h01, 8'h80, 1'b0, 1'b1, 2, 8'h00, 4'b0000, 4'b0000, 1'b0));
        foreach (q[i]) begin
            run_op(q[i], lat, out, fl, m, ld);
            checks++;
            if (lat !== q[i].lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", q[i].name, lat, q[i].lat); end
            checks++;
            if (out !== q[i].out) begin errors++; $display("FAIL %s out: got %h want %h", q[i].name, out, q[i].out); end
            checks++;
            if (fl !== q[i].fl) begin errors++; $display("FAIL %s nvzc: got %b want %b", q[i].name, fl, q[i].fl); end
            checks++;
            if (m !== q[i].mk) begin errors++; $display("FAIL %s mask: got %b want %b", q[i].name, m, q[i].mk); end
            checks++;
            if (ld !== q[i].ld) begin errors++; $display("FAIL %s load_A: got %b want %b", q[i].name, ld, q[i].ld); end
        end
    endtask

    // start held high through the EXEC, DEC_ADJ and DONE sampling edges:
    // only the first request counts, and the result is held afterwards.
    task automatic test_back_to_back();
        int n_done = 0;
        int n_load = 0;
        @(negedge clk);
        op = 4'h0; IN_ALU_A = 8'h12; IN_ALU_B = 8'h34; carry_in = 1'b0; decimal_in = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
            if (load_A === 1'b1) n_load++;
            if (k == 4) start = 1'b0;
        end
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", n_done); end
        checks++;
        if (n_load !== 1) begin errors++; $display("FAIL b2b_load_count: got %0d want 1", n_load); end
        checks++;
        if (OUT_ALU !== 8'h46) begin errors++; $display("FAIL b2b_out_held: got %h want 46", OUT_ALU); end
        checks++;
        if ({busy, done, load_A} !== 3'b000) begin
            errors++; $display("FAIL b2b_idle: got busy/done/ld=%b want 000", {busy, done, load_A});
        end
    endtask

    task automatic test_reset_abort();
        int n_done = 0;
        @(negedge clk);
        op = 4'h0; IN_ALU_A = 8'h58; IN_ALU_B = 8'h46; carry_in = 1'b1; decimal_in = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ((o_dbg_state !== 2'd2) || (busy !== 1'b1)) begin
            errors++; $display("FAIL abort_in_dec_adj: got state=%0d busy=%b want state=2 busy=1", o_dbg_state, busy);
        end
        reset_ALU = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({OUT_ALU, flag_N, flag_V, flag_Z, flag_C, flag_mask, load_A, done, busy} !== 19'd0) begin
            errors++;
            $display("FAIL abort_outputs: got out=%h nvzc=%b%b%b%b mask=%b ld=%b done=%b busy=%b want all 0",
                     OUT_ALU, flag_N, flag_V, flag_Z, flag_C, flag_mask, load_A, done, busy);
        end
        checks++;
        if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d want 0", o_dbg_state); end
        reset_ALU = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if ((done === 1'b1) || (load_A === 1'b1)) n_done++;
        end
        checks++;
        if (n_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d strobes want 0", n_done); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        start = 1'b0; reset_ALU = 1'b1; op = 4'h0;
        IN_ALU_A = 8'h00; IN_ALU_B = 8'h00; carry_in = 1'b0; decimal_in = 1'b0;
        test_reset();
        test_arith();
        test_logic_shift();
        test_cmp_reserved();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
